// File: rtl/key_debounce_irq.sv
// key_debounce_irq: memory-mapped debouncer for 8 board keys.
//
// Each raw key is polarity-corrected, passed through a 2-flop synchroniser
// and filtered by a per-key STABLE/COUNT state machine with a 20-bit
// counter. A new level is accepted only after it has been seen for
// DB_CYCLES consecutive cycles. Accepted presses set sticky EDGE flags;
// IRQ is the registered OR of the enabled flags.
//
// Register window (word index on Addr):
//   0 STATE   debounced levels, read-only
//   1 EDGE    sticky press flags, write-1-to-clear
//   2 MASK    interrupt enables, read/write
//   3 RELEASE sticky release flags, write-1-to-clear (only with the
//             KEY_RELEASE_EDGE_EN macro defined; otherwise reads 0)
//
// Bus handshake: there is no ready. A write is taken on every rising clk
// edge where WE is high, using Addr and Din[7:0] (Din[31:8] is ignored);
// reads are combinational from Addr with no side effects.
//
// Optional feature macro: KEY_RELEASE_EDGE_EN.

module key_debounce_irq #(
  parameter int unsigned DB_CYCLES      = 500000,
  parameter bit          KEY_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [7:0]  user_key,
  output logic        IRQ
);

  localparam logic [19:0] CNT_MAX = 20'(DB_CYCLES - 1);

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } key_state_e;

  // Polarity-corrected keys: 1 always means "pressed" from here on.
  logic [7:0] key_in;

  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;

  // Per-key FSM state and counter; fsm_q is the observable FSM state.
  key_state_e  fsm_q [8];
  key_state_e  fsm_d [8];
  logic [19:0] cnt_q [8];
  logic [19:0] cnt_d [8];

  logic [7:0] state_q, state_d;
  logic [7:0] edge_q,  edge_d;
  logic [7:0] mask_q,  mask_d;
  logic       irq_q,   irq_d;

  // Acceptance pulses from the debounce FSMs.
  logic [7:0] press_set;

  logic [7:0] w1c_edge;
  logic       din_unused;

`ifdef KEY_RELEASE_EDGE_EN
  logic [7:0] release_q, release_d;
  logic [7:0] release_set;
  logic [7:0] w1c_release;
`endif

  assign key_in     = KEY_ACTIVE_LOW ? ~user_key : user_key;
  assign din_unused = ^Din[31:8];

  // Synchroniser next-state: shift the corrected key levels through s1, s2.
  always_comb begin
    s1_d = key_in;
    s2_d = s1_q;
  end

  // Debounce FSMs: count consecutive cycles of disagreement with STATE.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      fsm_d[i] = fsm_q[i];
      cnt_d[i] = cnt_q[i];
    end
    state_d   = state_q;
    press_set = 8'h00;
`ifdef KEY_RELEASE_EDGE_EN
    release_set = 8'h00;
`endif
    for (int i = 0; i < 8; i++) begin
      case (fsm_q[i])
        ST_STABLE: begin
          if (s2_q[i] != state_q[i]) begin
            fsm_d[i] = ST_COUNT;
            cnt_d[i] = 20'd1;
          end else begin
            cnt_d[i] = 20'd0;
          end
        end
        ST_COUNT: begin
          if (s2_q[i] == state_q[i]) begin
            // Bounced back before qualifying: forget the attempt.
            fsm_d[i] = ST_STABLE;
            cnt_d[i] = 20'd0;
          end else if (cnt_q[i] == CNT_MAX) begin
            fsm_d[i]     = ST_STABLE;
            cnt_d[i]     = 20'd0;
            state_d[i]   = s2_q[i];
            press_set[i] = s2_q[i];
`ifdef KEY_RELEASE_EDGE_EN
            release_set[i] = ~s2_q[i];
`endif
          end else begin
            cnt_d[i] = cnt_q[i] + 20'd1;
          end
        end
      endcase
    end
  end

  // Software-visible registers and IRQ; a new set beats a same-cycle W1C.
  always_comb begin
    w1c_edge = (WE && (Addr == 2'd1)) ? Din[7:0] : 8'h00;
    edge_d   = (edge_q & ~w1c_edge) | press_set;
    mask_d   = (WE && (Addr == 2'd2)) ? Din[7:0] : mask_q;
`ifdef KEY_RELEASE_EDGE_EN
    w1c_release = (WE && (Addr == 2'd3)) ? Din[7:0] : 8'h00;
    release_d   = (release_q & ~w1c_release) | release_set;
    irq_d       = |((edge_q | release_q) & mask_q);
`else
    irq_d       = |(edge_q & mask_q);
`endif
  end

  // Read mux, combinational from Addr.
  always_comb begin
    Dout = 32'h0;
    case (Addr)
      2'd0: Dout = {24'h0, state_q};
      2'd1: Dout = {24'h0, edge_q};
      2'd2: Dout = {24'h0, mask_q};
`ifdef KEY_RELEASE_EDGE_EN
      2'd3: Dout = {24'h0, release_q};
`else
      2'd3: Dout = 32'h0;
`endif
      default: Dout = 32'h0;
    endcase
  end

  assign IRQ = irq_q;

  // State registers; reset discards any debounce in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q    <= 8'h00;
      s2_q    <= 8'h00;
      state_q <= 8'h00;
      edge_q  <= 8'h00;
      mask_q  <= 8'h00;
      irq_q   <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        fsm_q[i] <= ST_STABLE;
        cnt_q[i] <= 20'd0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      irq_q   <= irq_d;
      for (int i = 0; i < 8; i++) begin
        fsm_q[i] <= fsm_d[i];
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

`ifdef KEY_RELEASE_EDGE_EN
  // Sticky release flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      release_q <= 8'h00;
    end else begin
      release_q <= release_d;
    end
  end
`endif

endmodule
